// File: rtl/toy_bus_target_resp.sv
// ToyBus target endpoint: turns req beats into fixed-latency memory accesses and returns
// one credit-protected ack per request. Define TOY_BUS_TGT_ERR_EN to enable target-ID checking.

module toy_bus_target_resp #(
    parameter logic [3:0] NODE_ID   = 4'd2,
    parameter int         RD_LAT    = 1,
    parameter int         ACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        in0_req_vld,
    output logic        in0_req_rdy,
    input  logic [31:0] in0_req_addr,
    input  logic [3:0]  in0_req_strb,
    input  logic [31:0] in0_req_data,
    input  logic        in0_req_opcode,
    input  logic [3:0]  in0_req_src_id,
    input  logic [3:0]  in0_req_tgt_id,

    output logic        in0_ack_vld,
    input  logic        in0_ack_rdy,
    output logic        in0_ack_opcode,
    output logic [31:0] in0_ack_data,
    output logic [3:0]  in0_ack_src_id,
    output logic [3:0]  in0_ack_tgt_id,

    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
`ifdef TOY_BUS_TGT_ERR_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    localparam int AW = $clog2(ACK_DEPTH);
    localparam int IW = (AW > 0) ? AW : 1;
    localparam int PW = AW + 1;

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic       opcode;
        logic       err;
        logic [3:0] src_id;
    } stage_t;

    typedef struct packed {
        logic        opcode;
        logic [31:0] data;
        logic [3:0]  tgt_id;
    } ack_t;

    logic                    accept;
    logic                    req_err;
    logic                    mem_hit;

    logic [RD_LAT-1:0]       pipe_vld_q, pipe_vld_d;
    stage_t [RD_LAT-1:0]     pipe_q, pipe_d;

    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           occ_q, occ_d;
    logic [IW-1:0]           wr_idx, rd_idx;

    ack_t                    fifo_mem [ACK_DEPTH];
    ack_t                    push_entry;
    ack_t                    head;
    stage_t                  tail;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;

    // Credit check looks only at registered occupancy, so ack_rdy never reaches req_rdy.
    assign in0_req_rdy = rst_n & (occ_q < PW'(ACK_DEPTH));
    assign accept      = in0_req_vld & in0_req_rdy;

`ifdef TOY_BUS_TGT_ERR_EN
    assign req_err = (in0_req_tgt_id != NODE_ID);
`else
    logic [3:0] unused_tgt_id;
    assign req_err       = 1'b0;
    assign unused_tgt_id = in0_req_tgt_id;
`endif

    assign mem_hit   = accept & ~req_err;
    assign mem_en    = mem_hit;
    assign mem_we    = mem_hit & in0_req_opcode;
    assign mem_addr  = mem_hit ? in0_req_addr : '0;
    assign mem_wstrb = (mem_hit & in0_req_opcode) ? in0_req_strb : '0;
    assign mem_wdata = (mem_hit & in0_req_opcode) ? in0_req_data : '0;

    always_comb begin : pipe_next
        // NOTE: every signal gets a default first so no path through this block infers a latch.
        pipe_vld_d = '0;
        pipe_d     = '0;

        pipe_vld_d[0]        = accept;
        pipe_d[0].opcode     = in0_req_opcode;
        pipe_d[0].err        = req_err;
        pipe_d[0].src_id     = in0_req_src_id;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_d[i]     = pipe_q[i-1];
        end
    end

    // The last stage lines up with mem_rdata, so it is captured straight into the FIFO.
    assign push = pipe_vld_q[RD_LAT-1];
    assign tail = pipe_q[RD_LAT-1];

    always_comb begin : push_build
        push_entry        = '0;
        push_entry.opcode = tail.opcode;
        push_entry.tgt_id = tail.src_id;
        if (tail.err) begin
            push_entry.data = ERR_DATA;
        end else if (tail.opcode) begin
            push_entry.data = 32'h0;
        end else begin
            push_entry.data = mem_rdata;
        end
    end

    generate
        if (AW == 0) begin : g_single
            assign wr_idx = '0;
            assign rd_idx = '0;
        end else begin : g_multi
            assign wr_idx = wr_ptr_q[IW-1:0];
            assign rd_idx = rd_ptr_q[IW-1:0];
        end
    endgenerate

    // Pointers carry one extra MSB; equal pointers mean empty.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign head       = fifo_mem[rd_idx];

    assign in0_ack_vld    = rst_n & ~fifo_empty;
    assign in0_ack_opcode = in0_ack_vld & head.opcode;
    assign in0_ack_data   = in0_ack_vld ? head.data : '0;
    assign in0_ack_src_id = in0_ack_vld ? NODE_ID : '0;
    assign in0_ack_tgt_id = in0_ack_vld ? head.tgt_id : '0;

    assign pop = in0_ack_vld & in0_ack_rdy;

    always_comb begin : ptr_next
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        occ_d    = occ_q + PW'(accept) - PW'(pop);
    end

    always_ff @(posedge clk) begin : ctrl_regs
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (!rst_n) begin
            pipe_vld_q <= '0;
            pipe_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            pipe_q     <= pipe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
        end
    end

    // NOTE: the ack storage has no reset; pointers alone decide which entries are live.
    always_ff @(posedge clk) begin : fifo_write
        if (push) begin
            fifo_mem[wr_idx] <= push_entry;
        end
    end

`ifdef TOY_BUS_TGT_ERR_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin : err_next
        err_cnt_d = err_cnt_q;
        if (accept && req_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin : err_reg
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_toy_bus_target_resp.sv
// Directed bench for toy_bus_target_resp: an RD_LAT=1 instance for protocol/backpressure/reset
// cases and an RD_LAT=2 instance for streaming; inputs driven and outputs sampled on negedge.

module tb_toy_bus_target_resp;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Instance A: RD_LAT=1, ACK_DEPTH=4
    logic        a_req_vld, a_req_rdy, a_op;
    logic [31:0] a_addr, a_wdata;
    logic [3:0]  a_strb, a_src, a_tgt;
    logic        a_ack_vld, a_ack_rdy, a_ack_op;
    logic [31:0] a_ack_data;
    logic [3:0]  a_ack_src, a_ack_tgt;
    logic        a_mem_en, a_mem_we;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [3:0]  a_mem_wstrb;
`ifdef TOY_BUS_TGT_ERR_EN
    logic [7:0]  a_err_cnt;
    logic [7:0]  b_err_cnt;
`endif

    // Instance B: RD_LAT=2, ACK_DEPTH=4
    logic        b_req_vld, b_req_rdy;
    logic [31:0] b_addr;
    logic        b_ack_vld, b_ack_op;
    logic [31:0] b_ack_data;
    logic [3:0]  b_ack_src, b_ack_tgt;
    logic        b_mem_en, b_mem_we;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [3:0]  b_mem_wstrb;

    toy_bus_target_resp #(.NODE_ID(4'd2), .RD_LAT(1), .ACK_DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .in0_req_vld(a_req_vld), .in0_req_rdy(a_req_rdy), .in0_req_addr(a_addr),
        .in0_req_strb(a_strb), .in0_req_data(a_wdata), .in0_req_opcode(a_op),
        .in0_req_src_id(a_src), .in0_req_tgt_id(a_tgt),
        .in0_ack_vld(a_ack_vld), .in0_ack_rdy(a_ack_rdy), .in0_ack_opcode(a_ack_op),
        .in0_ack_data(a_ack_data), .in0_ack_src_id(a_ack_src), .in0_ack_tgt_id(a_ack_tgt),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
`ifdef TOY_BUS_TGT_ERR_EN
        , .err_cnt(a_err_cnt)
`endif
    );

    toy_bus_target_resp #(.NODE_ID(4'd2), .RD_LAT(2), .ACK_DEPTH(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .in0_req_vld(b_req_vld), .in0_req_rdy(b_req_rdy), .in0_req_addr(b_addr),
        .in0_req_strb(4'h0), .in0_req_data(32'h0), .in0_req_opcode(1'b0),
        .in0_req_src_id(4'd9), .in0_req_tgt_id(4'd2),
        .in0_ack_vld(b_ack_vld), .in0_ack_rdy(1'b1), .in0_ack_opcode(b_ack_op),
        .in0_ack_data(b_ack_data), .in0_ack_src_id(b_ack_src), .in0_ack_tgt_id(b_ack_tgt),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
`ifdef TOY_BUS_TGT_ERR_EN
        , .err_cnt(b_err_cnt)
`endif
    );

    // Memory models: word-addressed, byte-strobed writes, fixed read latency.
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] a_rd_q, b_rd1_q, b_rd2_q;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (a_mem_en && a_mem_we)
            mem_a[a_mem_addr[9:2]] <= merge(mem_a[a_mem_addr[9:2]], a_mem_wdata, a_mem_wstrb);
        if (a_mem_en && !a_mem_we) a_rd_q <= mem_a[a_mem_addr[9:2]];
        if (b_mem_en && !b_mem_we) b_rd1_q <= mem_b[b_mem_addr[9:2]];
        b_rd2_q <= b_rd1_q;
    end
    assign a_mem_rdata = a_rd_q;
    assign b_mem_rdata = b_rd2_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic a_set(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, input logic [3:0] src, input logic [3:0] tgt);
        a_req_vld = 1'b1;
        a_op      = op;
        a_addr    = addr;
        a_strb    = strb;
        a_wdata   = data;
        a_src     = src;
        a_tgt     = tgt;
    endtask

    task automatic a_idle();
        a_req_vld = 1'b0;
        a_op      = 1'b0;
        a_addr    = '0;
        a_strb    = '0;
        a_wdata   = '0;
        a_src     = '0;
        a_tgt     = 4'd2;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int next_req, got, sent, first_acc, first_ack, last_ack;

        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = 32'hC0DE_0000 + 32'(i);
        end
        mem_a[8'h10] = 32'h1234_5678;
        for (int i = 0; i < 6; i++) mem_a[8'h20 + i] = 32'hB000_0000 + 32'(i);
        a_rd_q = '0; b_rd1_q = '0; b_rd2_q = '0;

        a_idle();
        a_ack_rdy = 1'b1;
        b_req_vld = 1'b0;
        b_addr    = '0;
        rst_n     = 1'b0;

        // Reset: outputs quiet even with a request offered
        repeat (2) @(negedge clk);
        a_set(1'b0, 32'h40, 4'h0, 32'h0, 4'd3, 4'd2);
        #1;
        check("rst_req_rdy", a_req_rdy, 1'b0);
        check("rst_ack_vld", a_ack_vld, 1'b0);
        check("rst_mem_en", a_mem_en, 1'b0);
        @(negedge clk);
        a_idle();
        rst_n = 1'b1;
        #1;
        check("post_rst_rdy", a_req_rdy, 1'b1);
        check("post_rst_ack_vld", a_ack_vld, 1'b0);

        // Single read, latency RD_LAT+1 = 2
        @(negedge clk);
        a_set(1'b0, 32'h40, 4'hF, 32'hFFFF_FFFF, 4'd3, 4'd2);
        #1;
        check("rd_mem_en", a_mem_en, 1'b1);
        check("rd_mem_we", a_mem_we, 1'b0);
        check("rd_mem_addr", a_mem_addr, 32'h40);
        check("rd_wstrb_forced", a_mem_wstrb, 4'h0);
        @(negedge clk);
        a_idle();
        #1;
        check("rd_ack_early", a_ack_vld, 1'b0);
        @(negedge clk);
        check("rd_ack_vld", a_ack_vld, 1'b1);
        check("rd_ack_data", a_ack_data, 32'h1234_5678);
        check("rd_ack_src", a_ack_src, 4'd2);
        check("rd_ack_tgt", a_ack_tgt, 4'd3);
        check("rd_ack_op", a_ack_op, 1'b0);
        @(negedge clk);
        check("rd_ack_popped", a_ack_vld, 1'b0);

        // Write then read with partial strobe
        @(negedge clk);
        a_set(1'b1, 32'h10, 4'b0011, 32'hA5A5_A5A5, 4'd1, 4'd2);
        #1;
        check("wr_mem_we", a_mem_we, 1'b1);
        check("wr_mem_wstrb", a_mem_wstrb, 4'b0011);
        check("wr_mem_wdata", a_mem_wdata, 32'hA5A5_A5A5);
        @(negedge clk);
        a_set(1'b0, 32'h10, 4'hF, 32'h0, 4'd1, 4'd2);
        #1;
        check("wr_rd_wstrb", a_mem_wstrb, 4'h0);
        @(negedge clk);
        a_idle();
        #1;
        check("wr_ack_vld", a_ack_vld, 1'b1);
        check("wr_ack_op", a_ack_op, 1'b1);
        check("wr_ack_data", a_ack_data, 32'h0);
        check("wr_ack_tgt", a_ack_tgt, 4'd1);
        @(negedge clk);
        check("wrrd_ack_op", a_ack_op, 1'b0);
        check("wrrd_ack_data", a_ack_data, 32'h0000_A5A5);
        @(negedge clk);

        // Backpressure: 6 reads offered, ack_rdy low
        a_ack_rdy = 1'b0;
        next_req  = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (next_req < 6) a_set(1'b0, 32'h80 + 32'(4 * next_req), 4'h0, 32'h0, 4'd7, 4'd2);
            else a_idle();
            #1;
            if (c >= 6) check("bp_stall_data", a_ack_data, 32'hB000_0000);
            if (a_req_vld && a_req_rdy) next_req++;
        end
        check("bp_accepted", 32'(next_req), 32'd4);
        check("bp_full_rdy", a_req_rdy, 1'b0);
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            a_ack_rdy = 1'b1;
            if (next_req < 6) a_set(1'b0, 32'h80 + 32'(4 * next_req), 4'h0, 32'h0, 4'd7, 4'd2);
            else a_idle();
            #1;
            if (c == 0) check("bp_rdy_lags_pop", a_req_rdy, 1'b0);
            if (a_req_vld && a_req_rdy) next_req++;
            if (a_ack_vld && a_ack_rdy) begin
                check("bp_ack_data", a_ack_data, 32'hB000_0000 + 32'(got));
                check("bp_ack_tgt", a_ack_tgt, 4'd7);
                got++;
            end
        end
        check("bp_ack_count", 32'(got), 32'd6);
        a_idle();

        // Streaming on instance B
        sent = 0; got = 0; first_acc = -1; first_ack = -1; last_ack = -1;
        for (int c = 0; c < 60 && got < 16; c++) begin
            @(negedge clk);
            b_req_vld = (sent < 16);
            b_addr    = 32'(4 * sent);
            #1;
            if (b_req_vld) begin
                check("st_rdy", b_req_rdy, 1'b1);
                if (b_req_rdy) begin
                    if (sent == 0) first_acc = cyc;
                    sent++;
                end
            end
            if (b_ack_vld) begin
                if (got == 0) first_ack = cyc;
                else check("st_ack_gap", 32'(cyc - last_ack), 32'd1);
                check("st_ack_data", b_ack_data, 32'hC0DE_0000 + 32'(got));
                last_ack = cyc;
                got++;
            end
        end
        b_req_vld = 1'b0;
        check("st_ack_count", 32'(got), 32'd16);
        check("st_first_lat", 32'(first_ack - first_acc), 32'd3);

        // Reset with three acks outstanding
        a_ack_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_set(1'b0, 32'h80, 4'h0, 32'h0, 4'd6, 4'd2);
        end
        @(negedge clk);
        a_idle();
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdy", a_req_rdy, 1'b0);
        @(negedge clk);
        rst_n     = 1'b1;
        a_ack_rdy = 1'b1;
        #1;
        check("mid_rst_ack_vld", a_ack_vld, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mid_rst_no_stale", a_ack_vld, 1'b0);
        end
        @(negedge clk);
        a_set(1'b0, 32'h40, 4'h0, 32'h0, 4'd4, 4'd2);
        @(negedge clk);
        a_idle();
        @(negedge clk);
        check("mid_rst_new_vld", a_ack_vld, 1'b1);
        check("mid_rst_new_data", a_ack_data, 32'h1234_5678);
        check("mid_rst_new_tgt", a_ack_tgt, 4'd4);
        @(negedge clk);

`ifdef TOY_BUS_TGT_ERR_EN
        // Misrouted request: no memory access, error data, counter saturates
        check("err_cnt_init", a_err_cnt, 8'd0);
        @(negedge clk);
        a_set(1'b0, 32'h40, 4'h0, 32'h0, 4'd3, 4'd5);
        #1;
        check("err_no_mem_en", a_mem_en, 1'b0);
        check("err_accepted", a_req_rdy, 1'b1);
        @(negedge clk);
        a_idle();
        #1;
        check("err_cnt_one", a_err_cnt, 8'd1);
        @(negedge clk);
        check("err_ack_vld", a_ack_vld, 1'b1);
        check("err_ack_data", a_ack_data, 32'hDEAD_BEEF);
        check("err_ack_tgt", a_ack_tgt, 4'd3);
        sent = 1;
        for (int c = 0; c < 600 && sent < 300; c++) begin
            @(negedge clk);
            a_set(1'b0, 32'h40, 4'h0, 32'h0, 4'd3, 4'd5);
            #1;
            if (a_req_vld && a_req_rdy) sent++;
        end
        @(negedge clk);
        a_idle();
        repeat (4) @(negedge clk);
        check("err_sent", 32'(sent), 32'd300);
        check("err_cnt_sat", a_err_cnt, 8'hFF);
`else
        // Without ID checking a foreign tgt_id still reaches memory
        @(negedge clk);
        a_set(1'b0, 32'h40, 4'h0, 32'h0, 4'd3, 4'd5);
        #1;
        check("noerr_mem_en", a_mem_en, 1'b1);
        @(negedge clk);
        a_idle();
        @(negedge clk);
        check("noerr_ack_data", a_ack_data, 32'h1234_5678);
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
